pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage IF/ID/EXE/MEM/WB pipeline. Detects RAW hazards between the ID-stage source registers and the EXE/MEM destinations, and flushes IF/ID and ID/EXE on a taken branch. Sequences the MEM-stage data-memory handshake through a wait FSM that freezes the whole pipeline until the memory is ready. Keeps saturating stall and flush performance counters.

Parameters:
FORWARD_EN, 0, 1 means forwarding exists and only load-use hazards stall; 0 means any RAW hazard against EXE or MEM stalls.
MEM_TIMEOUT, 16, maximum number of cycles in WAIT before the memory access is aborted.
CNT_W, 16, width of the performance counters.

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-low; state clears on the clock edge when reset==0
id_valid  in  1  ID stage holds a real instruction
id_src1  in  5  ID source register 1
id_src2  in  5  ID source register 2
id_two_src  in  1  ID instruction reads src2
exe_dest  in  5  EXE-stage destination
exe_wb_en  in  1  EXE instruction writes back
exe_mem_read  in  1  EXE instruction is a load
mem_dest  in  5  MEM-stage destination
mem_wb_en  in  1  MEM instruction writes back
exe_br_taken  in  1  branch in EXE resolved taken
mem_read  in  1  MEM stage load
mem_write  in  1  MEM stage store
sram_ready  in  1  memory completes the access this cycle
sram_req  out  1  memory request, held until ready
pc_freeze  out  1  hold PC
ifid_freeze  out  1  hold IF/ID
ifid_flush  out  1  clear IF/ID to NOP
idexe_flush  out  1  clear ID/EXE to NOP (bubble)
exemem_freeze  out  1  hold ID/EXE and EXE/MEM
memwb_bubble  out  1  write NOP into MEM/WB
mem_error  out  1  sticky memory timeout flag
stall_count  out  CNT_W  cycles with pc_freeze==1, saturating
flush_count  out  CNT_W  cycles with ifid_flush==1, saturating

Behaviour:
- Reset (reset==0 at edge): FSM to IDLE; wait counter, stall_count, flush_count and mem_error go to 0. Control outputs are combinational and are also 0 during reset.
- Register 0 never creates a hazard. src2 is compared only when id_two_src==1. No hazard is detected when id_valid==0.
- hz_exe = exe_wb_en and exe_dest matches a used source. With FORWARD_EN=1 it additionally requires exe_mem_read.
- hz_mem = mem_wb_en and mem_dest matches a used source. It applies only when FORWARD_EN=0.
- hazard = hz_exe or hz_mem.
- FSM states IDLE, WAIT, DONE:
  - IDLE: if mem_read or mem_write, go to WAIT.
  - WAIT: if sram_ready, go to DONE. Otherwise, when the wait counter reaches MEM_TIMEOUT-1, set mem_error and go to DONE. Otherwise increment the wait counter.
  - DONE: go to IDLE and clear the wait counter. DONE is the single advance cycle for the memory instruction; the next MEM op is sampled in the following IDLE.
- mem_stall = (IDLE and (mem_read or mem_write)) or WAIT.
- sram_req = mem_stall.
- Priority, evaluated combinationally in the same cycle:
  1. mem_stall: pc_freeze=ifid_freeze=exemem_freeze=memwb_bubble=1. Flushes are suppressed because the branch in EXE is frozen and re-evaluated later.
  2. exe_br_taken: ifid_flush=idexe_flush=1. The hazard stall is ignored because the ID instruction is discarded.
  3. hazard: pc_freeze=ifid_freeze=idexe_flush=1.
  4. Otherwise all control outputs are 0.
- A stall takes effect with zero latency: asserted in the same cycle as the triggering inputs. A load-use stall lasts one cycle with FORWARD_EN=1, and up to two cycles with FORWARD_EN=0.
- Counters increment at the edge when their condition holds and hold at all-ones. mem_error clears only on reset.
- Reset asserted mid-WAIT aborts the access: sram_req drops in that same cycle and the FSM is in IDLE next cycle.

Test Plan:
- Load-use, FORWARD_EN=1: exe_mem_read=1, exe_wb_en=1, exe_dest=5, id_src1=5 -> pc_freeze=ifid_freeze=idexe_flush=1 for 1 cycle; stall_count=1.
- RAW, FORWARD_EN=0: mem_wb_en=1, mem_dest=7, id_src2=7, id_two_src=1 -> stall asserted. Same stimulus with id_two_src=0, or with dest=0 -> no stall.
- Branch plus hazard in the same cycle: exe_br_taken=1 with a hazard present -> ifid_flush=idexe_flush=1, pc_freeze=0; flush_count increments by 1.
- Memory wait: mem_read=1, sram_ready rises on the 3rd cycle -> sram_req high and pipeline frozen for 3 cycles, DONE for 1 cycle with all controls 0, then IDLE.
- Timeout: mem_write=1, sram_ready=0 -> after 16 cycles in WAIT, mem_error=1 (sticky), FSM goes DONE then IDLE.
- Reset mid-WAIT: reset=0 during WAIT -> next cycle FSM in IDLE, counters=0, mem_error=0, sram_req=0 while reset is held.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW hazards, taken-branch
// flushes, MEM-stage memory wait FSM with timeout, and perf counters.
module pipeline_hazard_ctrl #(
  parameter bit FORWARD_EN  = 1'b0,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_two_src,
  input  logic [4:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [4:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             exe_br_taken,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             sram_ready,
  output logic             sram_req,
  output logic             pc_freeze,
  output logic             ifid_freeze,
  output logic             ifid_flush,
  output logic             idexe_flush,
  output logic             exemem_freeze,
  output logic             memwb_bubble,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] LAST = WW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state, state_nx;
  logic [WW-1:0] wait_cnt, wait_cnt_nx;
  logic          err_set;
  logic          e_hit, m_hit;
  logic          hz_exe, hz_mem, hazard;
  logic          mem_op, mem_stall;
  logic          sel_mem, sel_br, sel_hz;

  // x0 is hardwired, so it can never carry a dependency
  assign e_hit = id_valid && (exe_dest != 5'd0) &&
                 (exe_dest == id_src1 ||
                  (id_two_src && exe_dest == id_src2));
  assign m_hit = id_valid && (mem_dest != 5'd0) &&
                 (mem_dest == id_src1 ||
                  (id_two_src && mem_dest == id_src2));

  assign hz_exe = exe_wb_en && e_hit &&
                  (!FORWARD_EN || exe_mem_read);
  assign hz_mem = !FORWARD_EN && mem_wb_en && m_hit;
  assign hazard = hz_exe || hz_mem;

  assign mem_op    = mem_read || mem_write;
  assign mem_stall = (state == IDLE && mem_op) ||
                     (state == WAIT);

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    err_set     = 1'b0;
    unique case (state)
      IDLE: if (mem_op) state_nx = WAIT;
      WAIT: begin
        if (sram_ready) begin
          state_nx = DONE;
        end else if (wait_cnt == LAST) begin
          err_set  = 1'b1;
          state_nx = DONE;
        end else begin
          wait_cnt_nx = wait_cnt + 1'b1;
        end
      end
      DONE: begin
        state_nx    = IDLE;
        wait_cnt_nx = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  // reset forces every control low, aborting any access in flight
  assign sel_mem = reset && mem_stall;
  assign sel_br  = reset && !mem_stall && exe_br_taken;
  assign sel_hz  = reset && !mem_stall && !exe_br_taken && hazard;

  always_comb begin
    sram_req      = 1'b0;
    pc_freeze     = 1'b0;
    ifid_freeze   = 1'b0;
    ifid_flush    = 1'b0;
    idexe_flush   = 1'b0;
    exemem_freeze = 1'b0;
    memwb_bubble  = 1'b0;
    unique case (1'b1)
      sel_mem: begin
        sram_req      = 1'b1;
        pc_freeze     = 1'b1;
        ifid_freeze   = 1'b1;
        exemem_freeze = 1'b1;
        memwb_bubble  = 1'b1;
      end
      sel_br: begin
        ifid_flush  = 1'b1;
        idexe_flush = 1'b1;
      end
      sel_hz: begin
        pc_freeze   = 1'b1;
        ifid_freeze = 1'b1;
        idexe_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      mem_error   <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (err_set)
        mem_error <= 1'b1;
      if (pc_freeze && stall_count != '1)
        stall_count <= stall_count + 1'b1;
      if (ifid_flush && flush_count != '1)
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule
